match_ctrl: RTL and testbench
=============================

// Module: match_ctrl
// PURPOSE
//  Game sequencer for the 3x3 board. Debounces the move button, validates the one-hot cell select,
//  commits the mark, evaluates win/draw and passes the turn. Owns the authoritative board state.
//  Drives per-cell commit pulses to the square instances and status to the VGA renderer.
// PARAMETERS
//  DEBOUNCE_CNT  4   consecutive tick samples a new button level must hold to be accepted
// PORTS
//  clk        in   1   system clock, single clock domain
//  rst        in   1   asynchronous, active-low reset
//  tick       in   1   1 ms clock-enable pulse, one clk wide; debounce samples only on tick
//  button     in   1   raw move/restart button, active-low
//  select     in   9   cell select from switches, bit i = cell i (row i/3, col i%3)
//  board      out  18  cell i mark at [2i+1:2i]: 00 empty, 01 X, 10 O
//  turn       out  2   player to move: 01 X, 10 O
//  change     out  9   one-clk one-hot commit pulse to square i
//  winner     out  2   00 none, 01 X, 10 O, 11 draw
//  win_line   out  9   OR of all completed winning-line masks; 0 unless a player won
//  game_over  out  1   high from win/draw until restart
//  move_count out  4   committed marks, 0..9
//  reject     out  1   one-clk pulse on an illegal press
// BEHAVIOUR
//  Reset (async, rst=0): board=0, turn=01, change=0, winner=00, win_line=0, game_over=0,
//   move_count=0, reject=0, FSM=IDLE, debounce stable level=1 (released), counter=0. Mid-op reset aborts all.
//  Debounce: button goes through a 2-flop sync. On tick: sync!=stable -> cnt+1; cnt reaches DEBOUNCE_CNT
//   -> stable<=sync, cnt<=0. sync==stable -> cnt<=0. press = one-clk pulse on stable 1->0.
//  FSM states: IDLE, COMMIT, EVAL, OVER.
//  IDLE + press: select latched into sel_q. Legal iff exactly one bit set AND target cell empty.
//   Legal -> COMMIT. Illegal (zero, multi-hot, occupied) -> reject=1 for one clk, stay IDLE.
//  COMMIT (1 clk): board[sel_q]<=turn, change<=sel_q for this cycle only, move_count+1 -> EVAL.
//  EVAL (1 clk): compare 8 lines against turn (rows 007/038/1C0, cols 049/092/124, diags 111/054 hex).
//   Any line full of turn -> winner=turn, win_line=OR of matching masks, game_over=1, turn unchanged -> OVER.
//   Else move_count==9 -> winner=11, win_line=0, game_over=1 -> OVER.
//   Else turn toggles 01<->10 -> IDLE.
//  OVER + press: select==0 -> restart: all outputs to reset values in the next cycle, -> IDLE.
//   select!=0 -> reject pulse, stay OVER.
//  Latency: press at cycle N -> change/board at N+1 -> turn/winner/game_over at N+2.
//  Presses while in COMMIT/EVAL are dropped. select changes after the latch cycle are ignored.
//  Release has no action. The next move needs a new debounced 1->0 edge.
//  change and reject are never high in the same cycle.
//  move_count saturates at 9; it cannot exceed 9 because the FSM leaves for OVER first.
// STRUCTURE
//  Shared package ttt_pkg: MARK_EMPTY/X/O, WIN_NONE/DRAW, WIN_LINES[8] 9-bit masks, FSM state encoding.
//  One sub-module btn_debounce (sync + tick-gated counter, press pulse output). The rest of the logic
//   (FSM, line check, board register) lives in match_ctrl.
// TESTING
//  Reset, select=9'h010, press -> change=9'h010 for 1 clk, board[9:8]=01, turn=10, move_count=1, winner=00.
//  Then select=9'h010 press (occupied) -> reject 1 clk, board unchanged, turn stays 10. select=9'h003 -> reject.
//  X0 O3 X1 O4 X2 -> winner=01, win_line=9'h007, game_over=1, turn=01; press select=9'h020 -> reject only.
//  X0 O1 X2 O4 X3 O5 X7 O6 X8 -> winner=11, win_line=0, move_count=9, game_over=1.
//  button bounces low/high on alternate ticks for 3 ticks, then holds low 10 ticks -> exactly one commit.
//  rst pulsed low during COMMIT -> all outputs at reset values. In OVER, select=0 press -> board=0, turn=01.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared constants for the 3x3 game: mark/winner codes, winning-line masks and FSM encoding.
// Also provides a helper that extracts the cells holding a given mark.
package ttt_pkg;

   localparam logic [1:0] MARK_EMPTY = 2'b00;
   localparam logic [1:0] MARK_X     = 2'b01;
   localparam logic [1:0] MARK_O     = 2'b10;

   localparam logic [1:0] WIN_NONE   = 2'b00;
   localparam logic [1:0] WIN_DRAW   = 2'b11;

   // Index 0..2 rows, 3..5 columns, 6..7 diagonals; bit i = cell i.
   localparam logic [7:0][8:0] WIN_LINES = {
      9'h054, 9'h111, 9'h124, 9'h092, 9'h049, 9'h1C0, 9'h038, 9'h007
   };

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_COMMIT = 2'd1;
   localparam logic [1:0] ST_EVAL   = 2'd2;
   localparam logic [1:0] ST_OVER   = 2'd3;

   function automatic logic [8:0] cells_of(input logic [17:0] b, input logic [1:0] m);
      logic [8:0] r;
      r = '0;
      for (int i = 0; i < 9; i++) begin
         r[i] = (b[2*i +: 2] == m);
      end
      return r;
   endfunction

endpackage

// File: rtl/match_ctrl_btn_debounce.sv
// Button conditioner: two-flop synchroniser plus a tick-gated stability counter.
// Emits a one-clk press pulse when the accepted level falls from released to pressed.
module btn_debounce #(
   parameter int DEBOUNCE_CNT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic button,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CNT + 1);

   logic          sync_a;
   logic          sync_b;
   logic          stable;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_a <= 1'b1;
         sync_b <= 1'b1;
         stable <= 1'b1;
         cnt    <= '0;
         press  <= 1'b0;
      end else begin
         sync_a <= button;
         sync_b <= sync_a;
         press  <= 1'b0;
         if (tick) begin
            if (sync_b == stable) begin
               cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CNT - 1)) begin
               // The new level has now held for DEBOUNCE_CNT consecutive ticks.
               stable <= sync_b;
               cnt    <= '0;
               press  <= ~sync_b;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/match_ctrl.sv
// Game sequencer: validates a debounced move, commits it to the board, checks for a
// win or draw and passes the turn. Holds the authoritative board state.
module match_ctrl
   import ttt_pkg::*;
#(
   parameter int DEBOUNCE_CNT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick,
   input  logic        button,
   input  logic [8:0]  select,
   output logic [17:0] board,
   output logic [1:0]  turn,
   output logic [8:0]  change,
   output logic [1:0]  winner,
   output logic [8:0]  win_line,
   output logic        game_over,
   output logic [3:0]  move_count,
   output logic        reject
);

   logic       press;
   logic [1:0] state;
   logic [8:0] sel_q;
   logic [8:0] occupied;
   logic       legal;
   logic [8:0] hit;

   btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .button (button),
      .press  (press)
   );

   always_comb begin
      occupied = ~cells_of(board, MARK_EMPTY);
      legal    = $onehot(select) && ((select & occupied) == 9'd0);
   end

   // OR of every line completely owned by the player who just moved.
   always_comb begin
      logic [8:0] mine;
      mine = cells_of(board, turn);
      hit  = '0;
      for (int k = 0; k < 8; k++) begin
         if ((mine & WIN_LINES[k]) == WIN_LINES[k]) begin
            hit = hit | WIN_LINES[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         sel_q      <= '0;
         board      <= '0;
         turn       <= MARK_X;
         change     <= '0;
         winner     <= WIN_NONE;
         win_line   <= '0;
         game_over  <= 1'b0;
         move_count <= '0;
         reject     <= 1'b0;
      end else begin
         change <= '0;
         reject <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (press) begin
                  sel_q <= select;
                  if (legal) begin
                     state <= ST_COMMIT;
                  end else begin
                     reject <= 1'b1;
                  end
               end
            end
            ST_COMMIT: begin
               for (int i = 0; i < 9; i++) begin
                  if (sel_q[i]) begin
                     board[2*i +: 2] <= turn;
                  end
               end
               change <= sel_q;
               if (move_count != 4'd9) begin
                  move_count <= move_count + 4'd1;
               end
               state <= ST_EVAL;
            end
            ST_EVAL: begin
               if (hit != 9'd0) begin
                  winner    <= turn;
                  win_line  <= hit;
                  game_over <= 1'b1;
                  state     <= ST_OVER;
               end else if (move_count == 4'd9) begin
                  winner    <= WIN_DRAW;
                  win_line  <= '0;
                  game_over <= 1'b1;
                  state     <= ST_OVER;
               end else begin
                  turn  <= (turn == MARK_X) ? MARK_O : MARK_X;
                  state <= ST_IDLE;
               end
            end
            default: begin
               if (press) begin
                  if (select == 9'd0) begin
                     state      <= ST_IDLE;
                     sel_q      <= '0;
                     board      <= '0;
                     turn       <= MARK_X;
                     winner     <= WIN_NONE;
                     win_line   <= '0;
                     game_over  <= 1'b0;
                     move_count <= '0;
                  end else begin
                     reject <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_match_ctrl.sv
// Self-checking bench for match_ctrl: directed game scenarios plus a randomized game
// stream, all compared against a cell-array reference model of the game rules.
module tb_match_ctrl;
   import ttt_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        tick = 1'b0;
   logic        button = 1'b1;
   logic [8:0]  select = '0;
   logic [17:0] board;
   logic [1:0]  turn;
   logic [8:0]  change;
   logic [1:0]  winner;
   logic [8:0]  win_line;
   logic        game_over;
   logic [3:0]  move_count;
   logic        reject;

   int vectors = 0;
   int miscompares = 0;

   match_ctrl #(.DEBOUNCE_CNT(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .button     (button),
      .select     (select),
      .board      (board),
      .turn       (turn),
      .change     (change),
      .winner     (winner),
      .win_line   (win_line),
      .game_over  (game_over),
      .move_count (move_count),
      .reject     (reject)
   );

   always #5 clk = ~clk;

   // tick: one clk wide, every third clk
   initial begin
      forever begin
         repeat (2) @(negedge clk);
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
      end
   end

   // reference model
   logic [1:0] m_cell [9];
   logic [1:0] m_turn;
   logic [1:0] m_winner;
   logic [8:0] m_line;
   logic       m_over;
   int         m_count;
   int         exp_rej;
   int         rej_cnt;
   logic [8:0] exp_q [$];

   int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

   wire [35:0] status = {board, turn, winner, win_line, game_over, move_count};

   function automatic logic [35:0] exp_status();
      logic [17:0] b;
      for (int i = 0; i < 9; i++) b[2*i +: 2] = m_cell[i];
      return {b, m_turn, m_winner, m_line, m_over, 4'(m_count)};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 9; i++) m_cell[i] = MARK_EMPTY;
      m_turn = MARK_X; m_winner = WIN_NONE; m_line = '0; m_over = 1'b0; m_count = 0;
   endtask

   task automatic model_press(input logic [8:0] sel);
      int ones;
      int idx;
      ones = 0; idx = 0;
      exp_rej = 0;
      for (int i = 0; i < 9; i++) if (sel[i]) begin ones++; idx = i; end
      if (m_over) begin
         if (sel == 9'd0) model_reset();
         else exp_rej = 1;
      end else if (ones != 1 || m_cell[idx] != MARK_EMPTY) begin
         exp_rej = 1;
      end else begin
         m_cell[idx] = m_turn;
         m_count++;
         exp_q.push_back(sel);
         m_line = '0;
         for (int k = 0; k < 8; k++) begin
            if (m_cell[lines[k][0]] == m_turn && m_cell[lines[k][1]] == m_turn &&
                m_cell[lines[k][2]] == m_turn) begin
               m_line[lines[k][0]] = 1'b1;
               m_line[lines[k][1]] = 1'b1;
               m_line[lines[k][2]] = 1'b1;
            end
         end
         if (m_line != 9'd0) begin
            m_winner = m_turn; m_over = 1'b1;
         end else if (m_count == 9) begin
            m_winner = WIN_DRAW; m_over = 1'b1;
         end else begin
            m_turn = (m_turn == MARK_X) ? MARK_O : MARK_X;
         end
      end
   endtask

   // commit/reject monitor
   always @(negedge clk) begin
      if (rst) begin
         if (reject) rej_cnt++;
         if (change != 9'd0) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL change_unexpected got %h required none", change);
            end else begin
               logic [8:0] e;
               e = exp_q.pop_front();
               if (change !== e) begin
                  miscompares++;
                  $display("FAIL change_value got %h required %h", change, e);
               end
            end
            if (reject) begin
               miscompares++;
               $display("FAIL change_with_reject got reject=1 required 0");
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b0; button = 1'b1; select = '0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      model_reset();
      exp_q.delete();
      repeat (2) @(negedge clk);
   endtask

   task automatic press(input logic [8:0] sel);
      select = sel;
      model_press(sel);
      rej_cnt = 0;
      button = 1'b0;
      repeat (24) @(negedge clk);
      select = $urandom_range(0, 511);
      button = 1'b1;
      repeat (24) @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if (status !== exp_status() || change !== 9'd0 || reject !== 1'b0) begin
         miscompares++;
         $display("FAIL reset got %h/%h/%b required %h/0/0", status, change, reject, exp_status());
      end
   endtask

   task automatic test_first_move();
      press(9'h010);
      vectors++;
      if (status !== exp_status() || rej_cnt != 0 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL first_move got %h rej=%0d required %h rej=0", status, rej_cnt, exp_status());
      end
   endtask

   task automatic test_illegal();
      logic [8:0] sels [3] = '{9'h010, 9'h003, 9'h000};
      for (int i = 0; i < 3; i++) begin
         press(sels[i]);
         vectors++;
         if (status !== exp_status() || rej_cnt != 1) begin
            miscompares++;
            $display("FAIL illegal_%0d got %h rej=%0d required %h rej=1", i, status, rej_cnt, exp_status());
         end
      end
   endtask

   task automatic test_row_win();
      logic [8:0] seq [5] = '{9'h001, 9'h008, 9'h002, 9'h010, 9'h004};
      do_reset();
      foreach (seq[i]) press(seq[i]);
      vectors++;
      if (status !== exp_status() || winner !== 2'b01 || win_line !== 9'h007 ||
          game_over !== 1'b1 || turn !== 2'b01) begin
         miscompares++;
         $display("FAIL row_win got %h required %h", status, exp_status());
      end
      press(9'h020);
      vectors++;
      if (status !== exp_status() || rej_cnt != 1) begin
         miscompares++;
         $display("FAIL over_reject got %h rej=%0d required %h rej=1", status, rej_cnt, exp_status());
      end
   endtask

   task automatic test_restart();
      press(9'h000);
      vectors++;
      if (status !== exp_status() || board !== 18'd0 || turn !== 2'b01 || rej_cnt != 0) begin
         miscompares++;
         $display("FAIL restart got %h rej=%0d required %h rej=0", status, rej_cnt, exp_status());
      end
   endtask

   task automatic test_draw();
      logic [8:0] seq [9] = '{9'h001, 9'h002, 9'h004, 9'h010, 9'h008,
                              9'h020, 9'h080, 9'h040, 9'h100};
      do_reset();
      foreach (seq[i]) press(seq[i]);
      vectors++;
      if (status !== exp_status() || winner !== 2'b11 || win_line !== 9'd0 ||
          move_count !== 4'd9 || game_over !== 1'b1) begin
         miscompares++;
         $display("FAIL draw got %h required %h", status, exp_status());
      end
   endtask

   task automatic test_bounce();
      do_reset();
      select = 9'h100;
      model_press(9'h100);
      rej_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         button = (i % 2 == 1);
         repeat (3) @(negedge clk);
      end
      button = 1'b0;
      repeat (30) @(negedge clk);
      button = 1'b1;
      repeat (24) @(negedge clk);
      vectors++;
      if (status !== exp_status() || exp_q.size() != 0 || rej_cnt != 0) begin
         miscompares++;
         $display("FAIL bounce got %h pending=%0d required %h pending=0", status, exp_q.size(), exp_status());
      end
   endtask

   task automatic test_reset_mid();
      int waited;
      do_reset();
      select = 9'h001;
      button = 1'b0;
      waited = 0;
      while (dut.state != ST_COMMIT && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      vectors++;
      if (waited >= 200) begin
         miscompares++;
         $display("FAIL reset_mid_wait got timeout required COMMIT");
      end
      rst = 1'b0;
      button = 1'b1;
      #1;
      model_reset();
      exp_q.delete();
      vectors++;
      if (status !== exp_status() || change !== 9'd0 || reject !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid got %h/%h/%b required %h/0/0", status, change, reject, exp_status());
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (30) @(negedge clk);
      vectors++;
      if (status !== exp_status()) begin
         miscompares++;
         $display("FAIL reset_mid_after got %h required %h", status, exp_status());
      end
   endtask

   task automatic test_random();
      logic [8:0] sel;
      int r;
      do_reset();
      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 9);
         if (m_over && $urandom_range(0, 1) == 1) sel = 9'd0;
         else if (r < 7) sel = 9'd1 << $urandom_range(0, 8);
         else if (r == 7) sel = 9'd0;
         else sel = 9'($urandom_range(0, 511));
         press(sel);
         vectors++;
         if (status !== exp_status() || rej_cnt != exp_rej || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL random_%0d sel=%h got %h rej=%0d required %h rej=%0d",
                     n, sel, status, rej_cnt, exp_status(), exp_rej);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_first_move();
      test_illegal();
      test_row_win();
      test_restart();
      test_draw();
      test_bounce();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
